// File: rtl/issue_queue.sv
// In-order instruction issue queue between the fetcher and the decoder.
// It is a circular buffer of {inst, pc} pairs, and the head entry is presented combinationally.
module issue_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic               push_valid,
    input  logic [31:0]        push_inst,
    input  logic [31:0]        push_pc,
    output logic               queue_full,
    input  logic               if_station_idle,
    output logic               if_get_inst,
    output logic [31:0]        inst_from_pc,
    output logic [31:0]        pc_inst,
    output logic [PTR_W:0]     queue_count
);

    localparam logic [PTR_W:0]   LP_FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LP_PTR_ONE  = PTR_W'(1);

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];

    logic [PTR_W-1:0] r_hd;
    logic [PTR_W-1:0] r_tl;
    logic [PTR_W:0]   r_cnt;

    logic [PTR_W-1:0] w_hd_next;
    logic [PTR_W-1:0] w_tl_next;
    logic [PTR_W:0]   w_cnt_next;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_inst;
    logic [31:0]      w_head_pc;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == LP_FULL_CNT);

    // A full queue refuses pushes even when a pop frees a slot this same cycle.
    assign w_push = rdy_in & ~clear_in & ~rst_in & push_valid & ~w_full;
    assign w_pop  = rdy_in & ~clear_in & ~rst_in & ~w_empty & if_station_idle;

    always_comb begin
        w_hd_next  = r_hd;
        w_tl_next  = r_tl;
        w_cnt_next = r_cnt;
        if (rdy_in && clear_in) begin
            w_hd_next  = '0;
            w_tl_next  = '0;
            w_cnt_next = '0;
        end else begin
            if (w_push) begin
                w_tl_next = r_tl + LP_PTR_ONE;
            end
            if (w_pop) begin
                w_hd_next = r_hd + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   w_cnt_next = r_cnt + 1'b1;
                2'b01:   w_cnt_next = r_cnt - 1'b1;
                default: w_cnt_next = r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_hd  <= '0;
            r_tl  <= '0;
            r_cnt <= '0;
        end else begin
            r_hd  <= w_hd_next;
            r_tl  <= w_tl_next;
            r_cnt <= w_cnt_next;
        end
    end

    // The storage array is not reset: only entries between hd and tl are ever observed.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_inst[r_tl] <= push_inst;
            r_pc[r_tl]   <= push_pc;
        end
    end

    assign w_head_inst = r_inst[r_hd];
    assign w_head_pc   = r_pc[r_hd];

    assign inst_from_pc = w_empty ? 32'h0 : w_head_inst;
    assign pc_inst      = w_empty ? 32'h0 : w_head_pc;
    assign if_get_inst  = w_pop;
    assign queue_full   = w_full;
    assign queue_count  = r_cnt;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a vector table for single-cycle behaviour,
// followed by hand-written sequences for full, wrap, flush, stall and mid-stream reset.
module tb_issue_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        push_valid;
    logic [31:0] push_inst;
    logic [31:0] push_pc;
    logic        queue_full;
    logic        if_station_idle;
    logic        if_get_inst;
    logic [31:0] inst_from_pc;
    logic [31:0] pc_inst;
    logic [4:0]  queue_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    issue_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .push_valid      (push_valid),
        .push_inst       (push_inst),
        .push_pc         (push_pc),
        .queue_full      (queue_full),
        .if_station_idle (if_station_idle),
        .if_get_inst     (if_get_inst),
        .inst_from_pc    (inst_from_pc),
        .pc_inst         (pc_inst),
        .queue_count     (queue_count)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        clr;
        logic        pv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        idle;
        logic        e_full;
        logic [4:0]  e_cnt;
        logic        e_get;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[15];

    // Inputs change on the falling edge; outputs are checked 1 ns later, well before the next rising edge.
    task automatic drive(input logic rst, input logic rdy, input logic clr, input logic pv,
                         input logic [31:0] inst, input logic [31:0] pc, input logic idle);
        @(negedge clk_in);
        rst_in          = rst;
        rdy_in          = rdy;
        clear_in        = clr;
        push_valid      = pv;
        push_inst       = inst;
        push_pc         = pc;
        if_station_idle = idle;
        #1;
    endtask

    task automatic check(input string name, input logic e_full, input logic [4:0] e_cnt,
                         input logic e_get, input logic [31:0] e_inst, input logic [31:0] e_pc);
        n_assert++;
        if (queue_full !== e_full || queue_count !== e_cnt || if_get_inst !== e_get ||
            inst_from_pc !== e_inst || pc_inst !== e_pc) begin
            n_fail++;
            $display("FAIL %s: got full=%0b cnt=%0d get=%0b inst=%08h pc=%08h, want full=%0b cnt=%0d get=%0b inst=%08h pc=%08h",
                     name, queue_full, queue_count, if_get_inst, inst_from_pc, pc_inst,
                     e_full, e_cnt, e_get, e_inst, e_pc);
        end else begin
            $display("ok   %s: full=%0b cnt=%0d get=%0b inst=%08h pc=%08h",
                     name, queue_full, queue_count, if_get_inst, inst_from_pc, pc_inst);
        end
    endtask

    initial begin
        //            rst   rdy   clr   pv    inst          pc          idle  full  cnt   get   e_inst        e_pc
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00500093, 32'h0,      1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd1, 1'b1, 32'h00500093, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'h4,      1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222, 32'h8,      1'b0, 1'b0, 5'd1, 1'b0, 32'h11111111, 32'h4};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h33333333, 32'hC,      1'b1, 1'b0, 5'd2, 1'b1, 32'h11111111, 32'h4};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd2, 1'b1, 32'h22222222, 32'h8};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd1, 1'b1, 32'h33333333, 32'hC};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h44444444, 32'h40,     1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 32'h10,     1'b0, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h66666666, 32'h14,     1'b1, 1'b0, 5'd1, 1'b0, 32'h55555555, 32'h10};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h77777777, 32'h18,     1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,      1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        32'h0};

        // Reset: the reset state is checked while rst_in is still held high.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("reset", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].clr, vecs[i].pv, vecs[i].inst, vecs[i].pc, vecs[i].idle);
            check($sformatf("vec%0d", i), vecs[i].e_full, vecs[i].e_cnt, vecs[i].e_get, vecs[i].e_inst, vecs[i].e_pc);
        end

        // Full: 16 pushes fill the queue; the 17th push is dropped.
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10000000 + i, 32'(4 * i), 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h100, 1'b1);
        check("full_pop_drop_push", 1'b1, 5'd16, 1'b1, 32'h10000000, 32'h0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            check($sformatf("drain%0d", i), 1'b0, 5'(16 - i), 1'b1, 32'h10000000 + i, 32'(4 * i));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("drained_empty", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

        // Wrap-around: one entry in flight with a push and a pop each cycle for 40 cycles.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hA0000000, 32'h200, 1'b1);
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hA0000000 + k + 1, 32'h200 + 32'(4 * (k + 1)), 1'b1);
            check($sformatf("wrap%0d", k), 1'b0, 5'd1, 1'b1, 32'hA0000000 + k, 32'h200 + 32'(4 * k));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("wrap_last", 1'b0, 5'd1, 1'b1, 32'hA0000028, 32'h2A0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wrap_empty", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

        // Flush: clear_in discards 5 entries and the same-cycle push.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hB0000000 + i, 32'h300 + 32'(4 * i), 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hBBBBBBBB, 32'h3F0, 1'b1);
        check("flush_cycle", 1'b0, 5'd5, 1'b0, 32'hB0000000, 32'h300);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("flush_after", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hC0000000, 32'h400, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("flush_refill", 1'b0, 5'd1, 1'b1, 32'hC0000000, 32'h400);

        // Stall: with rdy_in low, push, pop and clear are all ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hD0000000 + i, 32'h500 + 32'(4 * i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, (i == 2), 1'b1, 32'hDDDDDDDD, 32'h5F0, 1'b1);
            check($sformatf("stall%0d", i), 1'b0, 5'd3, 1'b0, 32'hD0000000, 32'h500);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            check($sformatf("unstall%0d", i), 1'b0, 5'(3 - i), 1'b1, 32'hD0000000 + i, 32'h500 + 32'(4 * i));
        end

        // Reset mid-stream with 7 entries queued and a push pending.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hE0000000 + i, 32'h600 + 32'(4 * i), 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hEEEEEEEE, 32'h6F0, 1'b1);
        check("rst_cycle", 1'b0, 5'd7, 1'b0, 32'hE0000000, 32'h600);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("rst_after", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
- REQ-001 SHALL provide parameter DEPTH, default 16, meaning the number of queue entries (power of two, minimum 4).
- REQ-002 SHALL provide parameter PTR_W, default 4, meaning the pointer width, equal to log2(DEPTH).
- REQ-003 SHALL have one clock and a synchronous, active-high reset; the ports are named clk_in and rst_in.
- REQ-004 SHALL have ports as follows:
  - clk_in, input, 1, system clock, rising edge.
  - rst_in, input, 1, synchronous active-high reset.
  - rdy_in, input, 1, global ready; low freezes the block.
  - clear_in, input, 1, flush on branch mispredict or ROB clear.
  - push_valid, input, 1, fetcher presents an instruction this cycle.
  - push_inst, input, 32, fetched instruction word.
  - push_pc, input, 32, address of the fetched instruction.
  - queue_full, output, 1, no free entry; the fetcher must not push.
  - if_station_idle, input, 1, decoder reports that ROB, RS and LSB can all accept.
  - if_get_inst, output, 1, head entry is handed to the decoder this cycle.
  - inst_from_pc, output, 32, head instruction word.
  - pc_inst, output, 32, head instruction address.
  - queue_count, output, PTR_W+1, number of occupied entries.

Function
- REQ-005 SHALL store {inst, pc} pairs in a circular buffer of DEPTH entries, with head pointer hd, tail pointer tl and occupancy counter cnt.
- REQ-006 SHALL drive queue_full = (cnt == DEPTH) and queue_count = cnt, both combinational from registered state.
- REQ-007 SHALL accept a push on a rising edge only when rdy_in=1, clear_in=0, push_valid=1 and cnt<DEPTH; the entry is written at tl and tl advances by 1.
- REQ-008 SHALL silently drop a push while cnt==DEPTH, even if a pop occurs in the same cycle; there is no overwrite and no error flag.
- REQ-009 SHALL drive if_get_inst = rdy_in & ~clear_in & ~rst_in & (cnt!=0) & if_station_idle, combinationally.
- REQ-010 SHALL drive inst_from_pc and pc_inst from the entry at hd at all times; when cnt==0 they are 32'h0.
- REQ-011 SHALL pop on the rising edge when if_get_inst=1, so hd advances by 1 and exactly one instruction is issued per pop.
- REQ-012 SHALL have no push-to-pop bypass: an instruction pushed into an empty queue is first visible at the head one cycle later, so minimum latency is 1 cycle.
- REQ-013 SHALL, on a simultaneous accepted push and pop, leave cnt unchanged and advance both hd and tl.
- REQ-014 SHALL wrap both pointers from DEPTH-1 to 0 with no lost or duplicated entry.
- REQ-015 SHALL, when clear_in=1 and rdy_in=1, set hd=tl=cnt=0 on that edge; any same-cycle push is discarded and no pop occurs.
- REQ-016 SHALL hold all state while rdy_in=0; clear_in and push_valid are ignored and if_get_inst=0.
- REQ-017 SHALL never let cnt exceed DEPTH or go below 0, including under any combination of push, pop and clear.
- REQ-018 SHALL issue instructions strictly in push order.

Reset
- REQ-019 SHALL, when rst_in=1 on a rising edge, set hd=0, tl=0 and cnt=0 regardless of rdy_in and clear_in; storage contents are don't-care.
- REQ-020 SHALL present these outputs after reset: queue_full=0, queue_count=0, if_get_inst=0, inst_from_pc=32'h0, pc_inst=32'h0.
- REQ-021 SHALL drop a push or pop coinciding with rst_in=1; a reset mid-stream discards every queued entry.

Verification
- REQ-022 SHALL cover basic flow: with station idle, push inst 32'h00500093 at pc 32'h0 -> if_get_inst=1 on the next cycle with pc_inst=0, then queue_count returns to 0.
- REQ-023 SHALL cover full: hold if_station_idle=0 and push 17 instructions with pc 0,4,...,64 -> queue_full=1 after the 16th push, the 17th (pc 64) is dropped, and draining yields pc 0..60 in order.
- REQ-024 SHALL cover wrap-around: push and pop continuously for 40 cycles -> pc_inst sequence is monotonic in steps of 4 and queue_count stays at 1.
- REQ-025 SHALL cover flush: fill 5 entries, then assert clear_in with push_valid=1 -> next cycle queue_count=0, if_get_inst=0, and the pushed entry is absent.
- REQ-026 SHALL cover rdy_in stall: with 3 entries queued, hold rdy_in=0 for 4 cycles with push_valid=1 and station idle -> queue_count stays 3 and if_get_inst stays 0.
- REQ-027 SHALL cover reset mid-operation: assert rst_in with 7 entries queued and a push pending -> next cycle queue_count=0 and all outputs are at their REQ-020 reset values.
